count_checker: RTL

COUNT_CHECKER -- requirements
Module: count_checker

---
 rtl/count_pkg.sv | 17 +
 rtl/sat_cnt.sv | 33 +++
 rtl/count_checker.sv | 119 +++++++++++
 3 files changed

// File: rtl/count_pkg.sv
// Shared types and default parameters for the sequence checker.
package count_pkg;

  localparam int unsigned WIDTH_DEF  = 16;
  localparam int unsigned LOCK_N_DEF = 4;
  localparam int unsigned ERRW_DEF   = 16;

  // LOCK_N is limited to 1..255, so an 8-bit run counter never overflows.
  localparam int unsigned RUNW = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACQ    = 2'd1,
    LOCKED = 2'd2
  } state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_cnt #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] q
);

  logic [W-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (inc && (q_q != {W{1'b1}})) begin
      q_d = q_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/count_checker.sv
// Monitors a free-running counter stream, locks after LOCK_N correct
// increments and flags/counts sequence breaks while locked.
//
// state  | meaning
// IDLE   | no reference yet; next valid sample seeds the expected value
// ACQ    | counting consecutive matches toward LOCK_N
// LOCKED | stream trusted; matches counted, a mismatch is an error
module count_checker
  import count_pkg::*;
#(
  parameter int unsigned WIDTH  = WIDTH_DEF,
  parameter int unsigned LOCK_N = LOCK_N_DEF,
  parameter int unsigned ERRW   = ERRW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid,
  input  logic [WIDTH-1:0] data,
  input  logic             clear,
  output logic             locked,
  output logic             err,
  output logic [ERRW-1:0]  err_count,
  output logic [31:0]      match_count
);

  localparam logic [RUNW-1:0] LOCK_RUN = RUNW'(LOCK_N);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [RUNW-1:0]  run_q, run_d;
  logic [31:0]      match_q, match_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic             hit;
  logic             brk;

  assign hit = valid && (data == exp_q);

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    run_d   = run_q;
    match_d = match_q;
    brk     = 1'b0;
    if (clear) begin
      // The sample in a clear cycle is dropped, so exp is left untouched.
      state_d = IDLE;
      run_d   = '0;
      match_d = '0;
    end else if (valid) begin
      exp_d = data + WIDTH'(1);
      unique case (state_q)
        IDLE: begin
          state_d = ACQ;
          run_d   = '0;
        end
        ACQ: begin
          if (hit) begin
            run_d = run_q + RUNW'(1);
            if (run_d == LOCK_RUN) begin
              state_d = LOCKED;
            end
          end else begin
            run_d = '0;
          end
        end
        LOCKED: begin
          if (hit) begin
            match_d = match_q + 32'd1;
          end else begin
            brk     = 1'b1;
            state_d = ACQ;
            run_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          run_d   = '0;
        end
      endcase
    end
  end

  assign err_d    = brk;
  assign locked_d = (state_d == LOCKED);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      exp_q    <= '0;
      run_q    <= '0;
      match_q  <= '0;
      locked_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      exp_q    <= exp_d;
      run_q    <= run_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      err_q    <= err_d;
    end
  end

  sat_cnt #(
    .W(ERRW)
  ) u_err_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (brk),
    .clr  (clear),
    .q    (err_count)
  );

  assign locked      = locked_q;
  assign err         = err_q;
  assign match_count = match_q;

endmodule
